// File: rtl/sseg_scan_driver.sv
// sseg_scan_driver: scanned 4-digit seven-segment driver stepped by rising edges of sclk; define SSEG_BLANK_EN for leading-zero blanking.
module sseg_scan_driver #(
    parameter logic ACTIVE_LOW = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        sclk,
    input  logic [15:0] value,
    input  logic [3:0]  dp_in,
    output logic [3:0]  an,
    output logic [6:0]  seg,
    output logic        dp,
    output logic        frame
);
    localparam logic [15:0][6:0] HEX = {
        7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
        7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
    };
    logic        sclk_q, load_pending_q, frame_q, dp_o_q;
    logic [1:0]  idx_q;
    logic [15:0] val_q;
    logic [3:0]  dp_q, an_q, blank, en, nib, an_d;
    logic [6:0]  seg_q, seg_d;
    logic        tick, load, dp_d;
    assign tick = sclk & ~sclk_q;
    assign load = load_pending_q | (tick & (idx_q == 2'd3));
    assign nib  = val_q[{idx_q, 2'b00} +: 4];
`ifdef SSEG_BLANK_EN
    assign blank = {val_q[15:12] == 4'd0, val_q[15:8] == 8'd0, val_q[15:4] == 12'd0, 1'b0};
`else
    assign blank = 4'd0;
`endif
    assign en    = (4'b0001 << idx_q) & ~blank;
    assign an_d  = en ^ {4{ACTIVE_LOW}};
    assign seg_d = HEX[nib] ^ {7{ACTIVE_LOW}};
    assign dp_d  = (dp_q[idx_q] & en[idx_q]) ^ ACTIVE_LOW;
    always_ff @(posedge clk) begin
        if (rst) begin
            sclk_q         <= 1'b0;
            idx_q          <= 2'd0;
            load_pending_q <= 1'b1;
            val_q          <= 16'd0;
            dp_q           <= 4'd0;
            frame_q        <= 1'b0;
            an_q           <= {4{ACTIVE_LOW}};
            seg_q          <= {7{ACTIVE_LOW}};
            dp_o_q         <= ACTIVE_LOW;
        end else begin
            sclk_q <= sclk;
            if (tick) idx_q <= idx_q + 2'd1;
            if (load) begin
                val_q          <= value;
                dp_q           <= dp_in;
                load_pending_q <= 1'b0;
            end
            frame_q <= load;
            an_q    <= an_d;
            seg_q   <= seg_d;
            dp_o_q  <= dp_d;
        end
    end
    assign an    = an_q;
    assign seg   = seg_q;
    assign dp    = dp_o_q;
    assign frame = frame_q;
endmodule
